multicycle_cpu: RTL and testbench
=================================

MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath, register and address width.
REQ-002 SHALL have parameter NREGS, default 32: architectural registers; power of two, 2..32.
REQ-003 SHALL have parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port mem_req, output, 1 bit: memory access request.
REQ-007 SHALL have port mem_we, output, 1 bit: request is a write.
REQ-008 SHALL have port mem_addr, output, WIDTH bits: byte address.
REQ-009 SHALL have port mem_wdata, output, WIDTH bits: store data.
REQ-010 SHALL have port mem_rdata, input, WIDTH bits: fetch or load data; valid when mem_ready=1.
REQ-011 SHALL have port mem_ready, input, 1 bit: access completes this cycle.
REQ-012 SHALL have port a0, output, WIDTH bits: live value of register x10.
REQ-013 SHALL have port pc, output, WIDTH bits: current program counter.
REQ-014 SHALL have port trap, output, 1 bit: core halted on an illegal or misaligned operation.

Function
REQ-015 SHALL run the FSM states FETCH, DECODE, EXECUTE, MEM, WB and TRAP.
REQ-016 SHALL support ADD, SUB, AND, OR, SLT, ADDI, LW, SW, BEQ, BNE, LUI and JAL; every other encoding SHALL enter TRAP from DECODE.
REQ-017 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=pc and hold them until mem_ready=1; the instruction register SHALL latch mem_rdata in that cycle and the FSM SHALL go to DECODE.
REQ-018 DECODE SHALL read rs1/rs2 into operand registers and sign-extend the I/S/B/U/J immediate to WIDTH.
REQ-019 EXECUTE for R/I-type, LUI and JAL SHALL compute the result, then go to WB.
REQ-020 EXECUTE for BEQ/BNE SHALL set pc = taken ? pc+imm : pc+4 and go to FETCH; no WB state.
REQ-021 EXECUTE for LW/SW SHALL compute rs1+imm; if addr[1:0]!=0 it SHALL go to TRAP, else to MEM.
REQ-022 MEM SHALL hold mem_req=1 (mem_we=1 and mem_wdata=rs2 for SW) until mem_ready=1; LW SHALL then go to WB, SW SHALL set pc+=4 and go to FETCH.
REQ-023 WB SHALL write rd (JAL writes pc+4), set pc to pc+4 (JAL: pc+imm) and go to FETCH.
REQ-024 Writes to x0 SHALL be discarded, and x0 SHALL always read 0.
REQ-025 Register indices >= NREGS SHALL trap in DECODE.
REQ-026 Latency with mem_ready tied high: branch 3 cycles; ALU, LUI, JAL and SW 4 cycles; LW 5 cycles; each wait cycle adds 1.
REQ-027 All pc and address arithmetic SHALL wrap modulo 2^WIDTH; SLT SHALL be signed.
REQ-028 mem_req SHALL be 0 in DECODE, EXECUTE, WB and TRAP; mem_we, mem_addr and mem_wdata are don't-care when mem_req=0.
REQ-029 TRAP SHALL be absorbing: trap=1, pc frozen, no register or memory writes until reset.
REQ-030 mem_rdata SHALL be ignored while mem_ready=0.

Reset
REQ-031 On rst=1, without waiting for a clock edge: state=FETCH, pc=RESET_PC, trap=0, mem_req=0, mem_we=0, and all registers including a0 SHALL be 0.
REQ-032 Reset during a pending MEM or FETCH SHALL abandon the access; the first request after release is a fetch at RESET_PC on the first clk edge.

Structure
REQ-033 Package cpu_pkg SHALL hold the state enum, opcode/funct constants and ALU control codes.
REQ-034 The register file SHALL be the sub-module reg_file: parametrised by WIDTH and NREGS, with two asynchronous read ports and one synchronous write port.

Verification
REQ-035 Reset, ADDI x10,x0,5 then ADD x10,x10,x10 with mem_ready high -> a0=5 after cycle 4, a0=10 after cycle 8.
REQ-036 SW x10,8(x0) then LW x11,8(x0), with mem_ready low for 2 cycles in MEM -> write of addr 8 data 10 is seen once; x11=10; the LW takes 7 cycles.
REQ-037 BNE x0,x10,-8 with a0=10 at pc=0x10 -> pc=0x08 after 3 cycles; BEQ with equal operands -> branch taken; with unequal operands -> pc+4.
REQ-038 LW with addr=0x6, and separately opcode 0x7F -> trap=1 and pc frozen; no further mem_req for 20 cycles.
REQ-039 JAL x1,+0x100 at pc=0xFFFFFFF0 -> x1=0xFFFFFFF4 and pc=0x000000F0 (wrap); assert rst mid-MEM -> outputs return to reset values immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: FSM states, RV32 opcode/funct encodings and ALU control codes shared by the multicycle core.
package cpu_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP} state_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_PASS} alu_op_e;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
endpackage

// File: rtl/reg_file.sv
// reg_file: NREGS x WIDTH registers, two async read ports, one sync write port; x0 is never written.
module reg_file #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(NREGS)-1:0] raddr1_i,
  input  logic [$clog2(NREGS)-1:0] raddr2_i,
  output logic [WIDTH-1:0]         rdata1_o,
  output logic [WIDTH-1:0]         rdata2_o,
  output logic [WIDTH-1:0]         a0_o
);
  logic [WIDTH-1:0] regs_q [NREGS];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    else if (we_i && waddr_i != '0) regs_q[waddr_i] <= wdata_i;
  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];
  generate
    if (NREGS > 10) begin : g_a0
      assign a0_o = regs_q[10];
    end else begin : g_no_a0
      assign a0_o = '0;
    end
  endgenerate
endmodule

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: RV32 subset core, FETCH/DECODE/EXECUTE/MEM/WB with an absorbing TRAP state.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               NREGS    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] a0,
  output logic [WIDTH-1:0] pc,
  output logic             trap
);
  localparam int IW = $clog2(NREGS);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(4);
  state_e           state_q;
  logic [31:0]      ir_q, imm32;
  logic [WIDTH-1:0] pc_q, a_q, b_q, imm_q, res_q, res_d, imm_d, alu_b, rdata1, rdata2;
  logic             trap_q;
  logic [6:0]       op, f7;
  logic [4:0]       rd, rs1, rs2;
  logic [2:0]       f3;
  logic             is_r, is_addi, is_lw, is_sw, is_br, is_lui, is_jal;
  logic             uses_rs1, uses_rs2, uses_rd, legal, taken;
  alu_op_e          alu_op;
  assign {f7, rs2, rs1, f3, rd, op} = ir_q;
  always_comb begin
    is_r     = op == OP_R && ((f7 == F7_BASE && (f3 == F3_ADD || f3 == F3_SLT || f3 == F3_OR || f3 == F3_AND))
               || (f7 == F7_SUB && f3 == F3_ADD));
    is_addi  = op == OP_I && f3 == F3_ADD;
    is_lw    = op == OP_LW && f3 == F3_W;
    is_sw    = op == OP_SW && f3 == F3_W;
    is_br    = op == OP_BR && (f3 == F3_BEQ || f3 == F3_BNE);
    is_lui   = op == OP_LUI;
    is_jal   = op == OP_JAL;
    uses_rs2 = is_r | is_sw | is_br;
    uses_rs1 = uses_rs2 | is_addi | is_lw;
    uses_rd  = is_r | is_addi | is_lw | is_lui | is_jal;
    // Only the register fields an instruction actually uses are range-checked against NREGS.
    legal    = (uses_rs1 | uses_rd) && !(uses_rs1 && |(rs1 >> IW)) && !(uses_rs2 && |(rs2 >> IW))
               && !(uses_rd && |(rd >> IW));
    imm32    = is_lui ? {ir_q[31:12], 12'b0}
             : is_jal ? {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0}
             : is_br  ? {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0}
             : is_sw  ? {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]}
             :          {{20{ir_q[31]}}, ir_q[31:20]};
    imm_d    = WIDTH'($signed(imm32));
    alu_op   = is_lui ? ALU_PASS : !is_r ? ALU_ADD : f7 == F7_SUB ? ALU_SUB
             : f3 == F3_AND ? ALU_AND : f3 == F3_OR ? ALU_OR : f3 == F3_SLT ? ALU_SLT : ALU_ADD;
    alu_b    = is_r ? b_q : imm_q;
    res_d    = is_jal ? pc_q + STEP
             : alu_op == ALU_PASS ? imm_q
             : alu_op == ALU_SUB  ? a_q - alu_b
             : alu_op == ALU_AND  ? a_q & alu_b
             : alu_op == ALU_OR   ? a_q | alu_b
             : alu_op == ALU_SLT  ? WIDTH'($signed(a_q) < $signed(alu_b))
             :                      a_q + alu_b;
    taken    = (f3 == F3_BNE) ^ (a_q == b_q);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: if (mem_ready) begin
          ir_q    <= mem_rdata[31:0];
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          a_q     <= rdata1;
          b_q     <= rdata2;
          imm_q   <= imm_d;
          state_q <= legal ? S_EXECUTE : S_TRAP;
          trap_q  <= !legal;
        end
        S_EXECUTE: begin
          res_q <= res_d;
          if (is_br) begin
            pc_q    <= taken ? pc_q + imm_q : pc_q + STEP;
            state_q <= S_FETCH;
          end else if (is_lw || is_sw) begin
            state_q <= |res_d[1:0] ? S_TRAP : S_MEM;
            trap_q  <= |res_d[1:0];
          end else state_q <= S_WB;
        end
        S_MEM: if (mem_ready) begin
          if (is_lw) begin
            res_q   <= mem_rdata;
            state_q <= S_WB;
          end else begin
            pc_q    <= pc_q + STEP;
            state_q <= S_FETCH;
          end
        end
        S_WB: begin
          pc_q    <= is_jal ? pc_q + imm_q : pc_q + STEP;
          state_q <= S_FETCH;
        end
        default: trap_q <= 1'b1;
      endcase
    end
  reg_file #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we_i     (state_q == S_WB),
    .waddr_i  (rd[IW-1:0]),
    .wdata_i  (res_q),
    .raddr1_i (rs1[IW-1:0]),
    .raddr2_i (rs2[IW-1:0]),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2),
    .a0_o     (a0)
  );
  // Reset gates the request combinationally so a pending access is dropped without waiting for a clock.
  assign mem_req   = !rst && (state_q == S_FETCH || state_q == S_MEM);
  assign mem_we    = !rst && state_q == S_MEM && is_sw;
  assign mem_addr  = state_q == S_MEM ? res_q : pc_q;
  assign mem_wdata = b_q;
  assign pc        = pc_q;
  assign trap      = trap_q;
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed programs against a small word memory with optional data-access wait states.
module tb_multicycle_cpu;
  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, a0, pc;
  logic [31:0] mem [256];
  logic [31:0] wr_addr, wr_data;
  logic        wr_valid;
  int          stall_lim = 0, stall_cnt, wr_count, req_count, tests = 0, fails = 0, rc;

  multicycle_cpu dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .a0(a0), .pc(pc), .trap(trap)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_rdata = (wr_valid && mem_addr == wr_addr) ? wr_data : mem[mem_addr[9:2]];
    mem_ready = !(mem_req && mem_addr != pc && stall_cnt < stall_lim);
  end

  always @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt <= 0;
      wr_count  <= 0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      if (mem_req && mem_addr != pc) stall_cnt <= mem_ready ? 0 : stall_cnt + 1;
      if (mem_req && mem_we && mem_ready) begin
        wr_count <= wr_count + 1;
        wr_valid <= 1'b1;
        wr_addr  <= mem_addr;
        wr_data  <= mem_wdata;
      end
    end

  always @(negedge clk or posedge rst)
    if (rst) req_count <= 0;
    else if (mem_req) req_count <= req_count + 1;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1, input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3, input int rd, input logic [6:0] op);
    return {12'(imm), 5'(rs1), f3, 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [11:0] m;
    m = 12'(imm);
    return {m[11:5], 5'(rs2), 5'(rs1), 3'b010, m[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
    logic [12:0] m;
    m = 13'(imm);
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), f3, m[4:1], m[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] m;
    m = 21'(imm);
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6F};
  endfunction

  task automatic setup();
    rst = 1'b1;
    stall_lim = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #1;
  endtask
  task automatic go();
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    tests++; if (trap !== 1'b0) begin fails++; $display("FAIL reset_trap: got %b want 0", trap); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", mem_req); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", mem_we); end
    tests++; if (a0 !== 32'h0) begin fails++; $display("FAIL reset_a0: got %h want 0", a0); end
  endtask

  task automatic test_alu();
    setup();
    mem[0]  = enc_i(5, 0, 3'd0, 10, 7'h13);
    mem[1]  = enc_r(7'h00, 10, 10, 3'd0, 10);
    mem[2]  = enc_i(-3, 0, 3'd0, 11, 7'h13);
    mem[3]  = enc_r(7'h00, 10, 11, 3'd2, 10);
    mem[4]  = enc_r(7'h20, 11, 10, 3'd0, 10);
    mem[5]  = enc_r(7'h00, 11, 10, 3'd6, 10);
    mem[6]  = enc_i(240, 0, 3'd0, 12, 7'h13);
    mem[7]  = enc_r(7'h00, 12, 10, 3'd7, 10);
    mem[8]  = {20'h12345, 5'd10, 7'h37};
    mem[9]  = enc_i(7, 0, 3'd0, 0, 7'h13);
    mem[10] = enc_r(7'h00, 10, 0, 3'd0, 10);
    go();
    cyc(3);
    tests++; if (a0 !== 32'd0) begin fails++; $display("FAIL addi_early: got %h want 0", a0); end
    cyc(1);
    tests++; if (a0 !== 32'd5) begin fails++; $display("FAIL addi_c4: got %h want 5", a0); end
    cyc(4);
    tests++; if (a0 !== 32'd10) begin fails++; $display("FAIL add_c8: got %h want a", a0); end
    cyc(8);
    tests++; if (a0 !== 32'd1) begin fails++; $display("FAIL slt_signed: got %h want 1", a0); end
    cyc(4);
    tests++; if (a0 !== 32'd4) begin fails++; $display("FAIL sub: got %h want 4", a0); end
    cyc(4);
    tests++; if (a0 !== 32'hFFFFFFFD) begin fails++; $display("FAIL or: got %h want fffffffd", a0); end
    cyc(8);
    tests++; if (a0 !== 32'hF0) begin fails++; $display("FAIL and: got %h want f0", a0); end
    cyc(4);
    tests++; if (a0 !== 32'h12345000) begin fails++; $display("FAIL lui: got %h want 12345000", a0); end
    cyc(8);
    tests++; if (a0 !== 32'h12345000) begin fails++; $display("FAIL x0_discard: got %h want 12345000", a0); end
    tests++; if (pc !== 32'h2C) begin fails++; $display("FAIL alu_pc: got %h want 2c", pc); end
  endtask

  task automatic test_mem();
    setup();
    stall_lim = 2;
    mem[0]  = enc_j(64, 0);
    mem[16] = enc_i(10, 0, 3'd0, 10, 7'h13);
    mem[17] = enc_s(8, 10, 0);
    mem[18] = enc_i(8, 0, 3'd2, 11, 7'h03);
    mem[19] = enc_i(1, 11, 3'd0, 10, 7'h13);
    go();
    cyc(13);
    tests++; if (pc !== 32'h44) begin fails++; $display("FAIL sw_wait_pc: got %h want 44", pc); end
    tests++; if (wr_count !== 0) begin fails++; $display("FAIL sw_wait_nowrite: got %0d want 0", wr_count); end
    cyc(1);
    tests++; if (pc !== 32'h48) begin fails++; $display("FAIL sw_done_pc: got %h want 48", pc); end
    tests++; if (wr_addr !== 32'h8 || wr_data !== 32'd10) begin fails++; $display("FAIL sw_data: got %h/%h want 8/a", wr_addr, wr_data); end
    cyc(6);
    tests++; if (pc !== 32'h48) begin fails++; $display("FAIL lw_c6_pc: got %h want 48", pc); end
    cyc(1);
    tests++; if (pc !== 32'h4C) begin fails++; $display("FAIL lw_c7_pc: got %h want 4c", pc); end
    cyc(3);
    tests++; if (a0 !== 32'd10) begin fails++; $display("FAIL lw_use_early: got %h want a", a0); end
    cyc(1);
    tests++; if (a0 !== 32'd11) begin fails++; $display("FAIL lw_value: got %h want b", a0); end
    tests++; if (wr_count !== 1) begin fails++; $display("FAIL sw_once: got %0d want 1", wr_count); end
  endtask

  task automatic test_branch();
    setup();
    mem[0] = enc_i(10, 0, 3'd0, 10, 7'h13);
    mem[1] = enc_j(12, 0);
    mem[4] = enc_b(-8, 10, 0, 3'd1);
    mem[2] = enc_b(16, 10, 10, 3'd0);
    mem[6] = enc_b(100, 10, 0, 3'd0);
    mem[7] = enc_b(8, 10, 10, 3'd1);
    go();
    cyc(10);
    tests++; if (pc !== 32'h10) begin fails++; $display("FAIL bne_early: got %h want 10", pc); end
    cyc(1);
    tests++; if (pc !== 32'h08) begin fails++; $display("FAIL bne_taken: got %h want 8", pc); end
    cyc(3);
    tests++; if (pc !== 32'h18) begin fails++; $display("FAIL beq_taken: got %h want 18", pc); end
    cyc(3);
    tests++; if (pc !== 32'h1C) begin fails++; $display("FAIL beq_not_taken: got %h want 1c", pc); end
    cyc(3);
    tests++; if (pc !== 32'h20) begin fails++; $display("FAIL bne_not_taken: got %h want 20", pc); end
  endtask

  task automatic test_trap();
    setup();
    mem[0] = enc_i(6, 0, 3'd2, 11, 7'h03);
    go();
    cyc(2);
    tests++; if (trap !== 1'b0) begin fails++; $display("FAIL misalign_early: got %b want 0", trap); end
    cyc(1);
    tests++; if (trap !== 1'b1) begin fails++; $display("FAIL misalign_trap: got %b want 1", trap); end
    rc = req_count;
    cyc(20);
    tests++; if (req_count - rc !== 0) begin fails++; $display("FAIL misalign_quiet: got %0d reqs want 0", req_count - rc); end
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL misalign_pc: got %h want 0", pc); end
    setup();
    mem[0] = 32'h0000007F;
    go();
    cyc(1);
    tests++; if (trap !== 1'b0) begin fails++; $display("FAIL illegal_early: got %b want 0", trap); end
    cyc(1);
    tests++; if (trap !== 1'b1) begin fails++; $display("FAIL illegal_trap: got %b want 1", trap); end
    rc = req_count;
    cyc(20);
    tests++; if (req_count - rc !== 0) begin fails++; $display("FAIL illegal_quiet: got %0d reqs want 0", req_count - rc); end
    tests++; if (pc !== 32'h0 || trap !== 1'b1) begin fails++; $display("FAIL illegal_frozen: got %h/%b want 0/1", pc, trap); end
  endtask

  task automatic test_jal_wrap();
    setup();
    stall_lim = 1000;
    mem[0]    = enc_j(-16, 0);
    mem[8'hFC] = enc_j(256, 1);
    mem[8'h3C] = enc_r(7'h00, 0, 1, 3'd0, 10);
    mem[8'h3D] = enc_s(0, 10, 0);
    go();
    cyc(4);
    tests++; if (pc !== 32'hFFFFFFF0) begin fails++; $display("FAIL jal_back: got %h want fffffff0", pc); end
    cyc(4);
    tests++; if (pc !== 32'hF0) begin fails++; $display("FAIL jal_wrap_pc: got %h want f0", pc); end
    cyc(4);
    tests++; if (a0 !== 32'hFFFFFFF4) begin fails++; $display("FAIL jal_link: got %h want fffffff4", a0); end
    cyc(6);
    tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin fails++; $display("FAIL mem_pending: got %b/%b want 1/1", mem_req, mem_we); end
    tests++; if (wr_count !== 0) begin fails++; $display("FAIL mem_stalled: got %0d want 0", wr_count); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL rst_async_req: got %b/%b want 0/0", mem_req, mem_we); end
    tests++; if (pc !== 32'h0 || a0 !== 32'h0 || trap !== 1'b0) begin fails++; $display("FAIL rst_async_state: got %h/%h/%b want 0/0/0", pc, a0, trap); end
    go();
    #1;
    tests++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin fails++; $display("FAIL post_rst_fetch: got %b/%b/%h want 1/0/0", mem_req, mem_we, mem_addr); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_trap();
    test_jal_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
